// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the multiply/divide unit. Holds the
//               operation encodings, the unit's state enumeration and the
//               default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int MD_WIDTH = 32;

  // operation encodings carried on the operation bus
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_if
// Description : Request/result bundle between the execute stage and the
//               multiply/divide unit.
//               master (execute stage) drives : start, operation,
//                 read_data_1, read_data_2, move_hi, move_lo
//               slave (mult_div_unit) drives  : busy, done, div_by_zero,
//                 hi, lo
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if #(
  parameter int WIDTH = mips_pkg::MD_WIDTH
);

  logic             start;
  logic [1:0]       operation;
  logic [WIDTH-1:0] read_data_1;
  logic [WIDTH-1:0] read_data_2;
  logic             move_hi;
  logic             move_lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, operation, read_data_1, read_data_2, move_hi, move_lo,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, operation, read_data_1, read_data_2, move_hi, move_lo,
    output busy, done, div_by_zero, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/mult_div_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_datapath
// Description : Iterative datapath of the multiply/divide unit. A single
//               2*WIDTH accumulator serves both shift-add multiplication
//               (low half = multiplier, high half = partial product) and
//               restoring division (low half = dividend/quotient, high
//               half = partial remainder). Produces sign-corrected results.
//               Ports: clock, reset (async active-low), load_i (latch
//               operands), step_i (one iteration), op_i, opa_i, opb_i,
//               res_hi_o/res_lo_o (final HI/LO), div_zero_o (latched
//               divide-by-zero flag).
//               Macro MULT_DIV_SIGNED_EN enables signed mult/div.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_datapath import mips_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o,
  output logic             div_zero_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q;
  logic               is_div_q;
  logic               div_zero_q;

  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic               w_zero_div;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign w_zero_div = op_i[1] && (opb_i == '0);

`ifdef MULT_DIV_SIGNED_EN
  logic w_signed;
  logic neg_lo_q, neg_hi_q;

  assign w_signed = op_i[0];
  assign w_mag_a  = (w_signed && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign w_mag_b  = (w_signed && opb_i[WIDTH-1]) ? -opb_i : opb_i;

  // product/quotient sign follows operand sign mismatch; remainder follows
  // the dividend only
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (load_i) begin
      neg_lo_q <= w_signed && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
      neg_hi_q <= w_signed && opa_i[WIDTH-1] && op_i[1];
    end
  end

  assign w_prod = neg_lo_q ? -acc_q : acc_q;
  assign w_quot = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign w_rem  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
  logic w_unused_sign;

  assign w_unused_sign = op_i[0];
  assign w_mag_a       = opa_i;
  assign w_mag_b       = opb_i;
  assign w_prod        = acc_q;
  assign w_quot        = acc_q[WIDTH-1:0];
  assign w_rem         = acc_q[2*WIDTH-1:WIDTH];
`endif

  // shift-add: conditionally add the multiplicand into the upper half, then
  // shift the whole accumulator right with the carry entering at the top
  assign w_add = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q})
                          :  {1'b0, acc_q[2*WIDTH-1:WIDTH]};

  // restoring division: the shifted remainder can reach WIDTH+1 bits, but a
  // successful subtraction always leaves a value below the divisor, so the
  // low WIDTH bits of the difference are exact
  assign w_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, opb_q});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - opb_q;

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      // multiplication is commutative, so both kinds load identically; a
      // zero divisor keeps the raw dividend for the HI result
      acc_d = {{WIDTH{1'b0}}, (w_zero_div ? opa_i : w_mag_a)};
    end else if (step_i) begin
      if (is_div_q) begin
        acc_d = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], w_ge};
      end else begin
        acc_d = {w_add, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load_i) begin
        opb_q      <= w_mag_b;
        is_div_q   <= op_i[1];
        div_zero_q <= w_zero_div;
      end
    end
  end

  always_comb begin
    res_hi_o = w_prod[2*WIDTH-1:WIDTH];
    res_lo_o = w_prod[WIDTH-1:0];
    if (div_zero_q) begin
      res_hi_o = acc_q[WIDTH-1:0];
      res_lo_o = '1;
    end else if (is_div_q) begin
      res_hi_o = w_rem;
      res_lo_o = w_quot;
    end
  end

  assign div_zero_o = div_zero_q;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle multiply/divide unit beside the execute-stage
//               ALU. Owns the FSM, iteration counter, start/busy/done
//               handshake and the architectural HI/LO registers.
//               Ports: clock, reset (async active-low), md (slave side of
//               mult_div_unit_if: start, operation, read_data_1/2,
//               move_hi, move_lo in; busy, done, div_by_zero, hi, lo out).
//               Macro MULT_DIV_SIGNED_EN enables signed mult/div.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit import mips_pkg::*; #(
  parameter int WIDTH       = MD_WIDTH,
  parameter int COUNT_WIDTH = 6
) (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave md
);

  md_state_t              state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]       hi_q, lo_q;
  logic                   done_q;
  logic                   dbz_q;

  logic                   w_load, w_step, w_write, w_busy;
  logic                   w_div_zero;
  logic [WIDTH-1:0]       w_res_hi, w_res_lo;
  logic                   w_res_dz;

  assign w_div_zero = md.operation[1] && (md.read_data_2 == '0);

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (md.start) begin
          if (!md.operation[1]) begin
            state_d = MULT;
          end else if (w_div_zero) begin
            state_d = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      MULT, DIV: begin
        if (cnt_q == COUNT_WIDTH'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_write = 1'b0;
    w_busy  = 1'b1;
    case (state_q)
      IDLE: begin
        w_load = md.start;
        w_busy = 1'b0;
      end
      MULT, DIV: w_step  = 1'b1;
      DONE:      w_write = 1'b1;
      default:   w_busy  = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_load) begin
      cnt_d = COUNT_WIDTH'(WIDTH);
    end else if (w_step) begin
      cnt_d = cnt_q - COUNT_WIDTH'(1);
    end
  end

  // HI/LO only change on a completed result or an idle move; a start in the
  // same cycle as a move takes priority and drops the move
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= w_write;
      if (w_load) begin
        dbz_q <= 1'b0;
      end else if (w_write) begin
        dbz_q <= w_res_dz;
      end
      if (w_write) begin
        hi_q <= w_res_hi;
        lo_q <= w_res_lo;
      end else if (state_q == IDLE && !md.start) begin
        if (md.move_hi) begin
          hi_q <= md.read_data_1;
        end
        if (md.move_lo) begin
          lo_q <= md.read_data_1;
        end
      end
    end
  end

  mult_div_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clock      (clock),
    .reset      (reset),
    .load_i     (w_load),
    .step_i     (w_step),
    .op_i       (md.operation),
    .opa_i      (md.read_data_1),
    .opb_i      (md.read_data_2),
    .res_hi_o   (w_res_hi),
    .res_lo_o   (w_res_lo),
    .div_zero_o (w_res_dz)
  );

  assign md.busy        = w_busy;
  assign md.done        = done_q;
  assign md.div_by_zero = dbz_q;
  assign md.hi          = hi_q;
  assign md.lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. Expected results are
//               queued when an operation is started and compared when done
//               pulses. Honours MULT_DIV_SIGNED_EN for the signed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
  import mips_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          t0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  exp_t m_e;

  mult_div_unit_if #(.WIDTH(32)) md();

  mult_div_unit #(
    .WIDTH       (32),
    .COUNT_WIDTH (6)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: returns {div_by_zero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic        sgn;
    longint      sa, sbv, q, r;
    logic [63:0] p;
`ifdef MULT_DIV_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!op[1]) begin
      if (sgn) p = 64'(sa * sbv);
      else     p = {32'd0, a} * {32'd0, b};
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = sa / sbv;
      r = sa % sbv;
      return {1'b0, r[31:0], q[31:0]};
    end
    return {1'b0, a % b, a / b};
  endfunction

  // compare every completed result against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && md.done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        m_e = sb.pop_front();
        check_eq({m_e.tag, "_hi"}, {32'd0, md.hi}, {32'd0, m_e.hi});
        check_eq({m_e.tag, "_lo"}, {32'd0, md.lo}, {32'd0, m_e.lo});
        check_eq({m_e.tag, "_dz"}, {63'd0, md.div_by_zero}, {63'd0, m_e.dz});
        check_eq({m_e.tag, "_lat"}, 64'(cyc - m_e.t0), 64'(m_e.lat));
      end
    end
  end

  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic mvh, input logic mvl,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e;
    @(negedge clk);
    md.start       = 1'b1;
    md.operation   = op;
    md.read_data_1 = a;
    md.read_data_2 = b;
    md.move_hi     = mvh;
    md.move_lo     = mvl;
    e.tag = tag; e.hi = ehi; e.lo = elo; e.dz = edz;
    e.lat = edz ? 1 : 33;
    e.t0  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    md.start   = 1'b0;
    md.move_hi = 1'b0;
    md.move_lo = 1'b0;
    check_eq({tag, "_busy"}, {63'd0, md.busy}, 64'd1);
  endtask

  task automatic issue_model(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b);
    logic [64:0] r;
    r = model(op, a, b);
    issue(tag, op, a, b, 1'b0, 1'b0, r[63:32], r[31:0], r[64]);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check_eq({tag, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
    check_eq({tag, "_post_busy"}, {63'd0, md.busy}, 64'd0);
    check_eq({tag, "_post_done"}, {63'd0, md.done}, 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n          = 1'b0;
    md.start       = 1'b0;
    md.operation   = MD_MULTU;
    md.read_data_1 = '0;
    md.read_data_2 = '0;
    md.move_hi     = 1'b0;
    md.move_lo     = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_hi",   {32'd0, md.hi}, 64'd0);
    check_eq("rst_lo",   {32'd0, md.lo}, 64'd0);
    check_eq("rst_busy", {63'd0, md.busy}, 64'd0);
    check_eq("rst_done", {63'd0, md.done}, 64'd0);
    check_eq("rst_dz",   {63'd0, md.div_by_zero}, 64'd0);
    rst_n = 1'b1;

    // full-width unsigned product
    issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_done("multu_max");

    // divide with an ignored start (and move) while busy
    issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd2, 32'd14, 1'b0);
    check_eq("hold_hi", {32'd0, md.hi}, 64'hFFFF_FFFE);
    repeat (3) @(negedge clk);
    md.start = 1'b1; md.operation = MD_MULTU; md.move_hi = 1'b1;
    md.read_data_1 = 32'd50; md.read_data_2 = 32'd5;
    @(negedge clk);
    md.start = 1'b0; md.move_hi = 1'b0;
    check_eq("busy_move_ign", {32'd0, md.hi}, 64'hFFFF_FFFE);
    wait_done("divu_100_7");
    repeat (3) @(negedge clk);

    // divide by zero
    issue("divu_5_0", MD_DIVU, 32'd5, 32'd0, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    wait_done("divu_5_0");

    // moves in IDLE
    md.move_hi = 1'b1; md.read_data_1 = 32'hA5A5_A5A5;
    @(negedge clk);
    md.move_hi = 1'b0;
    check_eq("mthi_hi", {32'd0, md.hi}, 64'hA5A5_A5A5);
    check_eq("mthi_lo", {32'd0, md.lo}, 64'hFFFF_FFFF);
    check_eq("mthi_dz", {63'd0, md.div_by_zero}, 64'd1);
    md.move_hi = 1'b1; md.move_lo = 1'b1; md.read_data_1 = 32'h1234_5678;
    @(negedge clk);
    md.move_hi = 1'b0; md.move_lo = 1'b0;
    check_eq("mtboth_hi", {32'd0, md.hi}, 64'h1234_5678);
    check_eq("mtboth_lo", {32'd0, md.lo}, 64'h1234_5678);

    // start beats a simultaneous move_lo; start clears div_by_zero
    issue("mvlo_start", MD_MULTU, 32'h0000_1111, 32'd3, 1'b0, 1'b1,
          32'd0, 32'h0000_3333, 1'b0);
    check_eq("dz_clear", {63'd0, md.div_by_zero}, 64'd0);
    check_eq("mvlo_held", {32'd0, md.lo}, 64'h1234_5678);
    wait_done("mvlo_start");

`ifdef MULT_DIV_SIGNED_EN
    issue("mult_m3_5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    wait_done("mult_m3_5");
    issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done("div_m7_2");
    issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
          32'd0, 32'h8000_0000, 1'b0);
    wait_done("div_ovf");
`else
    // signed encodings behave as unsigned in this build
    issue("mult_as_u", MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0,
          32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
    wait_done("mult_as_u");
    issue("div_as_u", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0,
          32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    wait_done("div_as_u");
`endif

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      issue_model($sformatf("rnd%0d", i), op, a, b);
      wait_done($sformatf("rnd%0d", i));
    end

    issue("multu_2_32", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0,
          32'd1, 32'd0, 1'b0);
    wait_done("multu_2_32");

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    md.start = 1'b1; md.operation = MD_MULTU;
    md.read_data_1 = 32'h1234_5678; md.read_data_2 = 32'd9;
    @(negedge clk);
    md.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_hi",   {32'd0, md.hi}, 64'd0);
    check_eq("abort_lo",   {32'd0, md.lo}, 64'd0);
    check_eq("abort_busy", {63'd0, md.busy}, 64'd0);
    check_eq("abort_done", {63'd0, md.done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue("multu_6_7", MD_MULTU, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, 32'd42, 1'b0);
    wait_done("multu_6_7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
